// File: rtl/rf_mp.sv
// Multi-port register file: two prioritised write ports, NR read ports,
// optional write-to-read bypass, optional registered read stage, per-register busy scoreboard.
module rf_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rbusy,
  input  logic             bset,
  input  logic [AW-1:0]    baddr
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [NR*DW-1:0] rd_d;
  logic [NR-1:0]    rbusy_d;
  logic [AW-1:0]    ra_k;

  // Port 1 is tested first so it wins an address collision with port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG != 0 && i == 0)      mem_q[i] <= '0;
        else if (we1 && wa1 == AW'(i))    mem_q[i] <= wd1;
        else if (we0 && wa0 == AW'(i))    mem_q[i] <= wd0;
      end
    end
  end

  // A new producer (bset) outranks a retiring one on the same register.
  always_comb begin
    busy_d = busy_q;
    if (we1)  busy_d[wa1]   = 1'b0;
    if (bset) busy_d[baddr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  always_comb begin
    rd_d    = '0;
    rbusy_d = '0;
    ra_k    = '0;
    for (int k = 0; k < NR; k++) begin
      ra_k = ra[k*AW +: AW];
      if (ZERO_REG != 0 && ra_k == '0) begin
        rd_d[k*DW +: DW] = '0;
        rbusy_d[k]       = 1'b0;
      end else if (BYPASS != 0 && we1 && wa1 == ra_k) begin
        rd_d[k*DW +: DW] = wd1;
        rbusy_d[k]       = 1'b0;
      end else if (BYPASS != 0 && we0 && wa0 == ra_k) begin
        rd_d[k*DW +: DW] = wd0;
        rbusy_d[k]       = busy_q[ra_k];
      end else begin
        rd_d[k*DW +: DW] = mem_q[ra_k];
        rbusy_d[k]       = busy_q[ra_k];
      end
    end
  end

  if (READ_LAT == 1) begin : g_reg
    logic [NR*DW-1:0] rd_q;
    logic [NR-1:0]    rbusy_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_q    <= '0;
        rbusy_q <= '0;
      end else begin
        rd_q    <= rd_d;
        rbusy_q <= rbusy_d;
      end
    end

    assign rd    = rd_q;
    assign rbusy = rbusy_q;
  end else begin : g_comb
    assign rd    = rd_d;
    assign rbusy = rbusy_d;
  end

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: a combinational/bypassed 2-port instance and a registered,
// non-bypassed 4-port instance, both checked against an array-based reference.
module tb_rf_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0, bset = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, baddr = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [9:0]  ra_a = '0;
  logic [19:0] ra_b = '0;
  logic [63:0] rd_a;
  logic [127:0] rd_b;
  logic [1:0]  rbusy_a;
  logic [3:0]  rbusy_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [32];
  logic        m_busy [32];

  always #5 clk = ~clk;

  rf_mp #(.DW(32), .AW(5), .NR(2), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) u_comb (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
    .bset(bset), .baddr(baddr)
  );

  rf_mp #(.DW(32), .AW(5), .NR(4), .ZERO_REG(1), .BYPASS(0), .READ_LAT(1)) u_reg (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
    .bset(bset), .baddr(baddr)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {busy, data} as the register file should present it for address a.
  function automatic logic [32:0] model_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0)                    return 33'd0;
    if (byp && we1 && wa1 == a)       return {1'b0, wd1};
    if (byp && we0 && wa0 == a)       return {m_busy[a], wd0};
    return {m_busy[a], m_mem[a]};
  endfunction

  function automatic void model_clock();
    if (we0 && wa0 != 5'd0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 5'd0) m_mem[wa1] = wd1;
    if (we1)  m_busy[wa1]   = 1'b0;
    if (bset) m_busy[baddr] = 1'b1;
    m_busy[0] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Entered shortly after a rising edge with inputs already driven; leaves 1 time unit after the next edge.
  task automatic step();
    logic [32:0] exp_b [4];
    logic [32:0] e;
    #1;
    for (int k = 0; k < 2; k++) begin
      e = model_read(ra_a[k*5 +: 5], 1'b1);
      check_val("comb_rd", 128'(rd_a[k*32 +: 32]), 128'(e[31:0]));
      check_val("comb_busy", 128'(rbusy_a[k]), 128'(e[32]));
    end
    for (int k = 0; k < 4; k++) exp_b[k] = model_read(ra_b[k*5 +: 5], 1'b0);
    @(posedge clk);
    if (rst) model_clock();
    #1;
    for (int k = 0; k < 4; k++) begin
      check_val("reg_rd", 128'(rd_b[k*32 +: 32]), 128'(exp_b[k][31:0]));
      check_val("reg_busy", 128'(rbusy_b[k]), 128'(exp_b[k][32]));
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Readback after reset on every port
    for (int a = 0; a < 32; a++) begin
      ra_a = {2{5'(a)}};
      ra_b = {4{5'(a)}};
      #1;
      check_val("rst_rd", 128'(rd_a), 128'd0);
      step();
    end

    // Write port collision: port 1 wins; writes to r0 dropped
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222_2222;
    step();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
    we1 = 1'b0;
    ra_a = {5'd0, 5'd7};
    ra_b = {5'd0, 5'd7, 5'd0, 5'd7};
    step();
    idle_inputs();
    #1;
    check_val("prio_r7", 128'(rd_a[31:0]), 128'h2222_2222);
    check_val("r0_zero", 128'(rd_a[63:32]), 128'd0);
    step();

    // Same-cycle bypass on the combinational instance
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hA5A5_0001;
    ra_a = {5'd7, 5'd5};
    ra_b = {4{5'd5}};
    #1;
    check_val("bypass_rd", 128'(rd_a[31:0]), 128'hA5A5_0001);
    step();
    idle_inputs();
    #1;
    check_val("nobyp_old", 128'(rd_b[31:0]), 128'd0);
    step();

    // Scoreboard set / clear / set-wins
    bset = 1'b1; baddr = 5'd9;
    ra_a = {2{5'd9}};
    ra_b = {4{5'd9}};
    step();
    bset = 1'b0;
    #1;
    check_val("busy_set", 128'(rbusy_a[0]), 128'd1);
    step();
    step();
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0909;
    #1;
    check_val("busy_byp_clr", 128'(rbusy_a[0]), 128'd0);
    step();
    we1 = 1'b0;
    #1;
    check_val("busy_clr", 128'(rbusy_a[0]), 128'd0);
    step();
    bset = 1'b1; baddr = 5'd9;
    step();
    bset = 1'b1; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0990;
    step();
    idle_inputs();
    #1;
    check_val("busy_set_wins", 128'(rbusy_a[0]), 128'd1);
    step();

    // Registered four-port read
    we0 = 1'b1; wa0 = 5'd3;  wd0 = 32'h0000_0033;
    we1 = 1'b1; wa1 = 5'd31; wd1 = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    ra_b = {5'd31, 5'd0, 5'd3, 5'd3};
    step();
    check_val("reg4_rd", rd_b, {32'hFFFF_FFFF, 32'h0, 32'h33, 32'h33});

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      we0   = 1'($urandom);
      we1   = 1'($urandom);
      bset  = ($urandom_range(0, 3) == 0);
      wa0   = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wa1   = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      baddr = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wd0   = $urandom;
      wd1   = $urandom;
      ra_a  = ($urandom % 2) ? {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))} : 10'($urandom);
      ra_b  = 20'($urandom);
      step();
    end

    // Reset mid-operation
    idle_inputs();
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0044;
    ra_a = {2{5'd4}};
    ra_b = {4{5'd4}};
    step();
    idle_inputs();
    step();
    check_val("pre_rst_r4", 128'(rd_b[31:0]), 128'h44);
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0099;
    bset = 1'b1; baddr = 5'd4;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_val("rst_async_rd", rd_b, 128'd0);
    check_val("rst_async_busy", 128'(rbusy_b), 128'd0);
    @(posedge clk);
    #1;
    check_val("rst_hold_rd", rd_b, 128'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("post_rst_r4", 128'(rd_a[31:0]), 128'd0);
    check_val("post_rst_busy", 128'(rbusy_a), 128'd0);
    @(posedge clk);
    #1;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0077;
    step();
    idle_inputs();
    #1;
    check_val("first_wr", 128'(rd_a[31:0]), 128'h77);
    step();
    step();
    check_val("first_wr_reg", 128'(rd_b[31:0]), 128'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
